serial_parallel: RTL



---
 rtl/serial_parallel_pkg.sv | 19 +
 rtl/serial_parallel_if.sv | 25 ++
 rtl/sp_comma_detect.sv | 28 ++
 rtl/serial_parallel.sv | 107 ++++++++++
 4 files changed

// File: rtl/serial_parallel_pkg.sv
// Shared definitions for the serial-to-parallel lane receiver: byte width,
// default comma symbol and FSM state encoding.
package serial_parallel_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] COMMA_DEF = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    // Last bit of a byte slot once the bit counter is aligned.
    function automatic logic is_boundary(input logic [2:0] cnt);
        return cnt == 3'd7;
    endfunction

endpackage

// File: rtl/serial_parallel_if.sv
// Lane bus between the serial source and the serial_parallel receiver:
// the serial bit in, the recovered byte, its valid flag and lane status out.
interface serial_parallel_if;
    import serial_parallel_pkg::*;

    logic              data_in;
    logic [BYTE_W-1:0] data_out;
    logic              valid_out;
    logic              active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );

endinterface

// File: rtl/sp_comma_detect.sv
// Seven-bit history shift register; the incoming bit completes a candidate
// byte every cycle, which is compared against the comma symbol.
module sp_comma_detect
    import serial_parallel_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA = COMMA_DEF
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [BYTE_W-1:0] cand,
    output logic              is_comma
);

    logic [BYTE_W-2:0] sr_q;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= {sr_q[BYTE_W-3:0], data_in};
        end
    end

    assign cand     = {sr_q, data_in};
    assign is_comma = (cand == COMMA);

endmodule

// File: rtl/serial_parallel.sv
// Lane receiver: hunts for the comma bit by bit, counts aligned commas until
// the lane is declared active, then presents each non-comma byte.
// Optional macro SP_VALID_PULSE_EN turns valid_out into a one-cycle pulse.
module serial_parallel
    import serial_parallel_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA       = COMMA_DEF,
    parameter int                COMMA_COUNT = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    serial_parallel_if.slave bus
);

    localparam logic [3:0] CC = 4'(COMMA_COUNT);

    logic [BYTE_W-1:0] cand;
    logic              is_comma;

    state_e            state_q;
    logic [2:0]        bit_cnt_q;
    logic [3:0]        bc_cnt_q;
    logic [BYTE_W-1:0] data_q;
    logic              valid_q;
    logic              active_q;

    logic [3:0]        bc_cnt_d;
    logic              boundary;

    sp_comma_detect #(
        .COMMA (COMMA)
    ) u_comma_detect (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (bus.data_in),
        .cand     (cand),
        .is_comma (is_comma)
    );

    assign bc_cnt_d = bc_cnt_q + 4'd1;
    assign boundary = is_boundary(bit_cnt_q);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q   <= SEARCH;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 4'd0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
`ifdef SP_VALID_PULSE_EN
            valid_q <= 1'b0;
`endif
            case (state_q)
                SEARCH: begin
                    if (is_comma) begin
                        bit_cnt_q <= 3'd0;
                        bc_cnt_q  <= 4'd1;
                        if (CC == 4'd1) begin
                            state_q  <= ACTIVE;
                            active_q <= 1'b1;
                        end else begin
                            state_q <= SYNC;
                        end
                    end
                end
                SYNC: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary) begin
                        if (is_comma) begin
                            bc_cnt_q <= bc_cnt_d;
                            if (bc_cnt_d == CC) begin
                                state_q  <= ACTIVE;
                                active_q <= 1'b1;
                            end
                        end else begin
                            // Next edge starts a fresh bit-by-bit hunt.
                            bc_cnt_q <= 4'd0;
                            state_q  <= SEARCH;
                        end
                    end
                end
                ACTIVE: begin
                    // Alignment is locked until reset; commas only clear valid.
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary) begin
                        if (!is_comma) begin
                            data_q  <= cand;
                            valid_q <= 1'b1;
                        end else begin
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= SEARCH;
                end
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.active    = active_q;

endmodule
